// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - iterative DES round-subkey generator
//
// Purpose: loads a 64-bit DES key and hands out the sixteen 48-bit round
// subkeys one per valid/ready transfer, in K1..K16 or K16..K1 order.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         begin a new schedule (sampled only when idle)
//   decrypt       0 = K1..K16, 1 = K16..K1 (sampled with start)
//   key[64:1]     DES key, key[64] = DES bit 1; parity bits ignored
//   busy          schedule in progress
//   subkey_valid  subkey/round hold a valid subkey
//   subkey_ready  consumer takes the subkey this cycle
//   subkey[48:1]  current subkey, subkey[48] = DES bit 1
//   round[4:1]    position 0..15 of the presented subkey in output order
`timescale 1ns/1ps
module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [64:1] key,
  output logic        busy,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [48:1] subkey,
  output logic [4:1]  round
);

  typedef enum logic [1:0] {IDLE, LOAD, PRESENT} state_t;

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Output bit n of each table lives at vector index (width+1-n), so DES bit 1
  // is always the MSB of the vector.
  function automatic logic [56:1] pc1(input logic [64:1] k);
    logic [56:1] r;
    logic [6:0]  src;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      src = 7'(65 - PC1_TAB[i]);
      r[6'(56 - i)] = k[src];
    end
    return r;
  endfunction

  function automatic logic [48:1] pc2(input logic [56:1] cd);
    logic [48:1] r;
    logic [5:0]  src;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      src = 6'(57 - PC2_TAB[i]);
      r[6'(48 - i)] = cd[src];
    end
    return r;
  endfunction

  // Schedule entries 1, 2, 9 and 16 shift by one; all others by two.
  function automatic logic shift_two(input logic [4:0] n);
    return !(n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16);
  endfunction

  // Circular rotation of one 28-bit half. Left moves DES bit 2 into bit 1.
  function automatic logic [28:1] rotate(input logic [28:1] x,
                                         input logic left, input logic two);
    logic [28:1] r;
    if (left) r = two ? {x[26:1], x[28:27]} : {x[27:1], x[28]};
    else      r = two ? {x[2:1], x[28:3]}   : {x[1], x[28:2]};
    return r;
  endfunction

  state_t      state, state_next;
  logic [28:1] c, d, c_next, d_next;
  logic        dir, dir_next;
  logic [48:1] subkey_next;
  logic        valid_next;
  logic [4:1]  round_next;

  logic [56:1] cd_load;
  logic [4:0]  sched_idx;
  logic        two;
  logic [28:1] c_rot, d_rot;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      c            <= '0;
      d            <= '0;
      dir          <= 1'b0;
      subkey       <= '0;
      subkey_valid <= 1'b0;
      round        <= '0;
    end else begin
      state        <= state_next;
      c            <= c_next;
      d            <= d_next;
      dir          <= dir_next;
      subkey       <= subkey_next;
      subkey_valid <= valid_next;
      round        <= round_next;
    end
  end

  always_comb begin
    state_next  = state;
    c_next      = c;
    d_next      = d;
    dir_next    = dir;
    subkey_next = subkey;
    valid_next  = subkey_valid;
    round_next  = round;

    cd_load   = pc1(key);
    // Encrypt walks the schedule forward from entry 2 (entry 1 is applied at
    // load); decrypt walks it backward from entry 16, starting at C16 = C0.
    sched_idx = dir ? (5'd16 - {1'b0, round}) : ({1'b0, round} + 5'd2);
    two       = shift_two(sched_idx);
    c_rot     = rotate(c, !dir, two);
    d_rot     = rotate(d, !dir, two);

    case (state)
      IDLE: begin
        if (start) begin
          c_next     = decrypt ? cd_load[56:29] : rotate(cd_load[56:29], 1'b1, 1'b0);
          d_next     = decrypt ? cd_load[28:1]  : rotate(cd_load[28:1],  1'b1, 1'b0);
          dir_next   = decrypt;
          state_next = LOAD;
        end
      end
      LOAD: begin
        subkey_next = pc2({c, d});
        valid_next  = 1'b1;
        round_next  = '0;
        state_next  = PRESENT;
      end
      PRESENT: begin
        if (subkey_valid && subkey_ready) begin
          if (round != 4'd15) begin
            c_next      = c_rot;
            d_next      = d_rot;
            subkey_next = pc2({c_rot, d_rot});
            round_next  = round + 4'd1;
          end else begin
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - scoreboard bench for des_key_schedule
//
// Purpose: drives directed and random schedules, pushes expected subkeys from
// a table-driven DES key-schedule model into a queue, and a separate monitor
// compares every transferred subkey and checks hold stability.
// Ports: none (top-level bench).
`timescale 1ns/1ps
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic [64:1] key = '0;
  logic        busy;
  logic        subkey_valid;
  logic        subkey_ready = 1'b1;
  logic [48:1] subkey;
  logic [4:1]  round;

  des_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key(key),
    .busy(busy), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
    .subkey(subkey), .round(round)
  );

  always #5 clk = ~clk;

  localparam logic [64:1] VEC_KEY  = 64'h133457799BBCDFF1;
  localparam logic [64:1] PAR_KEY  = 64'h123456789ABCDEF0;
  localparam logic [64:1] PAR_MASK = 64'h0101010101010101;
  localparam logic [48:1] K1_VEC   = 48'h1B02EFFC7072;
  localparam logic [48:1] K2_VEC   = 48'h79AED9DBC9E5;
  localparam logic [48:1] K16_VEC  = 48'hCB3D8B0E17F5;

  typedef struct packed {
    logic [48:1] sk;
    logic [4:1]  rnd;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          vcount = 0;
  logic        rand_ready = 1'b0;
  logic [48:1] mk [1:16];

  int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                     10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                     16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                     44,49,39,56,34,53, 46,42,50,36,29,32};
  int shifts [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: Cr/Dr are C0/D0 rotated by the cumulative shift total, taken
  // directly from the DES bit numbering.
  task automatic model_keys(input logic [64:1] k);
    bit kb [1:64];
    bit c0 [1:28];
    bit d0 [1:28];
    bit cd [1:56];
    int tot;
    for (int b = 1; b <= 64; b++) kb[b] = k[65 - b];
    for (int i = 1; i <= 28; i++) begin
      c0[i] = kb[pc1_t[i - 1]];
      d0[i] = kb[pc1_t[i + 27]];
    end
    tot = 0;
    for (int r = 1; r <= 16; r++) begin
      tot += shifts[r - 1];
      for (int i = 1; i <= 28; i++) begin
        cd[i]      = c0[((i - 1 + tot) % 28) + 1];
        cd[28 + i] = d0[((i - 1 + tot) % 28) + 1];
      end
      for (int j = 1; j <= 48; j++) mk[r][49 - j] = cd[pc2_t[j - 1]];
    end
  endtask

  task automatic push_exp(input logic [64:1] k, input logic dec);
    exp_t e;
    model_keys(k);
    for (int n = 0; n < 16; n++) begin
      e.sk  = dec ? mk[16 - n] : mk[n + 1];
      e.rnd = 4'(n);
      if (k == VEC_KEY) begin
        if (!dec && n == 0)  e.sk = K1_VEC;
        if (!dec && n == 1)  e.sk = K2_VEC;
        if (!dec && n == 15) e.sk = K16_VEC;
        if (dec && n == 0)   e.sk = K16_VEC;
        if (dec && n == 14)  e.sk = K2_VEC;
        if (dec && n == 15)  e.sk = K1_VEC;
      end
      q.push_back(e);
    end
  endtask

  // Ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      subkey_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin
    logic        held;
    logic [48:1] h_sk;
    logic [4:1]  h_rnd;
    exp_t        e;
    held = 1'b0;
    h_sk = '0;
    h_rnd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else if (subkey_valid) begin
        vcount++;
        if (held) begin
          chk("hold_subkey", 64'(subkey), 64'(h_sk));
          chk("hold_round", 64'(round), 64'(h_rnd));
        end
        if (subkey_ready) begin
          held = 1'b0;
          chk("queue_nonempty", 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk($sformatf("subkey_r%0d", e.rnd), 64'(subkey), 64'(e.sk));
            chk("round", 64'(round), 64'(e.rnd));
          end
        end else begin
          held = 1'b1;
          h_sk = subkey;
          h_rnd = round;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // mode: 0 plain, 1 timing checks, 2 start lockout at round 5, 3 reset at round 7
  task automatic run_sched(input logic [64:1] kd, input logic [64:1] km,
                           input logic dec, input int mode);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("idle_before_start", 64'(busy), 64'd0);
    push_exp(km, dec);
    vcount = 0;
    start = 1'b1;
    key = kd;
    decrypt = dec;
    @(posedge clk);
    #1;
    start = 1'b0;
    key = $urandom();
    decrypt = 1'($urandom_range(0, 1));
    if (mode == 1) begin
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("valid_after_start", 64'(subkey_valid), 64'd0);
      cnt = 0;
      do begin
        @(posedge clk);
        #1;
        cnt++;
        if (cnt == 1) begin
          chk("valid_latency", 64'(subkey_valid), 64'd1);
          chk("round_first", 64'(round), 64'd0);
        end
      end while (busy && cnt < 100);
      chk("busy_fall_edges", 64'(cnt), 64'd17);
      chk("valid_cycles", 64'(vcount), 64'd16);
    end
    if (mode == 2 || mode == 3) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!(subkey_valid && round == (mode == 2 ? 4'd5 : 4'd7)) && cnt < 200);
      chk("reached_round", 64'(cnt < 200), 64'd1);
      if (mode == 2) begin
        start = 1'b1;
        key = ~kd;
        decrypt = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end else begin
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(subkey_valid), 64'd0);
        chk("rst_subkey", 64'(subkey), 64'd0);
        chk("rst_round", 64'(round), 64'd0);
        #2;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_resume_valid", 64'(subkey_valid), 64'd0);
        chk("no_resume_busy", 64'(busy), 64'd0);
      end
    end
    cnt = 0;
    @(negedge clk);
    while ((busy || q.size() != 0) && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    chk("sched_complete", 64'(busy || q.size() != 0), 64'd0);
    q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [64:1] rk;
    rst_n = 1'b0;
    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(subkey_valid), 64'd0);
    chk("reset_subkey", 64'(subkey), 64'd0);
    chk("reset_round", 64'(round), 64'd0);
    rst_n = 1'b1;

    run_sched(VEC_KEY, VEC_KEY, 1'b0, 1);
    run_sched(VEC_KEY, VEC_KEY, 1'b1, 1);
    rand_ready = 1'b1;
    run_sched(VEC_KEY, VEC_KEY, 1'b0, 0);
    rand_ready = 1'b0;
    run_sched(PAR_KEY, PAR_KEY, 1'b0, 0);
    run_sched(PAR_KEY ^ PAR_MASK, PAR_KEY, 1'b0, 0);
    run_sched(VEC_KEY, VEC_KEY, 1'b0, 2);
    run_sched(VEC_KEY, VEC_KEY, 1'b0, 3);
    run_sched(VEC_KEY, VEC_KEY, 1'b0, 0);
    for (int t = 0; t < 8; t++) begin
      rk = {$urandom(), $urandom()};
      rand_ready = 1'($urandom_range(0, 1));
      run_sched(rk, rk, 1'($urandom_range(0, 1)), 0);
    end
    rand_ready = 1'b0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
